// File: rtl/upsampler_h_zero_insert_window.sv
// Horizontal 2x zero-insertion feeder: turns a raster fp16 pixel stream into
// 1x3 windows (with col/row tags) over the zero-stuffed row, one per output sample.
module upsampler_h_zero_insert_window #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int WINDOW_WIDTH  = 3,
    parameter int WINDOW_HEIGHT = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [0:WINDOW_HEIGHT-1][0:WINDOW_WIDTH-1][FP_WIDTH_REG-1:0] window_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o
);

    localparam int COL_W = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [15:0]      TAIL_COL = 16'(2 * IMG_WIDTH - 1);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_EVEN   = 2'd1,
        S_TAIL   = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [COL_W-1:0]        in_col, in_col_next;
    logic [ROW_W-1:0]        row, row_next;
    logic [FP_WIDTH_REG-1:0] cur, cur_next;
    logic [0:WINDOW_HEIGHT-1][0:WINDOW_WIDTH-1][FP_WIDTH_REG-1:0] window_next;
    logic [15:0]             col_next, row_o_next;
    logic                    valid_next;

    // in_col is the index k of the pixel being worked on; cur holds p(k).
    // Odd windows are built from cur (p(k-1)) and the incoming pixel p(k).
    always_comb begin
        state_next  = state;
        in_col_next = in_col;
        row_next    = row;
        cur_next    = cur;
        window_next = window_o;
        col_next    = col_o;
        row_o_next  = row_o;
        valid_next  = 1'b0;
        case (state)
            S_ACCEPT: begin
                if (valid_i && ready_o) begin
                    cur_next    = data_i;
                    valid_next  = 1'b1;
                    row_o_next  = 16'(row);
                    window_next = '0;
                    if (in_col == '0) begin
                        window_next[0][1] = data_i;
                        col_next          = 16'd0;
                        if (IMG_WIDTH == 1) begin
                            state_next = S_TAIL;
                        end else begin
                            in_col_next = in_col + COL_W'(1);
                        end
                    end else begin
                        window_next[0][0] = cur;
                        window_next[0][2] = data_i;
                        col_next          = 16'(in_col) * 16'd2 - 16'd1;
                        state_next        = S_EVEN;
                    end
                end
            end
            S_EVEN: begin
                valid_next        = 1'b1;
                row_o_next        = 16'(row);
                window_next       = '0;
                window_next[0][1] = cur;
                col_next          = 16'(in_col) * 16'd2;
                if (in_col == LAST_COL) begin
                    state_next = S_TAIL;
                end else begin
                    in_col_next = in_col + COL_W'(1);
                    state_next  = S_ACCEPT;
                end
            end
            S_TAIL: begin
                // Right edge replicates the last pixel into the virtual s(2W).
                valid_next        = 1'b1;
                row_o_next        = 16'(row);
                window_next       = '0;
                window_next[0][0] = cur;
                window_next[0][2] = cur;
                col_next          = TAIL_COL;
                in_col_next       = '0;
                row_next          = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
                state_next        = S_ACCEPT;
            end
            default: begin
                state_next = S_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_ACCEPT;
            in_col   <= '0;
            row      <= '0;
            cur      <= '0;
            ready_o  <= 1'b0;
            valid_o  <= 1'b0;
            window_o <= '0;
            col_o    <= 16'd0;
            row_o    <= 16'd0;
        end else begin
            state    <= state_next;
            in_col   <= in_col_next;
            row      <= row_next;
            cur      <= cur_next;
            ready_o  <= (state_next == S_ACCEPT);
            valid_o  <= valid_next;
            window_o <= window_next;
            col_o    <= col_next;
            row_o    <= row_o_next;
        end
    end

endmodule

// File: tb/tb_upsampler_h_zero_insert_window.sv
// Scoreboard bench for upsampler_h_zero_insert_window: three instances
// (W=4/H=1, W=2/H=2, W=1/H=1) driven by directed pixel vectors.
module tb_upsampler_h_zero_insert_window;

    typedef struct packed {
        logic [15:0] col;
        logic [15:0] row;
        logic [47:0] win;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_s  [3];
    logic        valid_s [3];
    logic        ready_s [3];
    logic [47:0] win_s   [3];
    logic [15:0] col_s   [3];
    logic [15:0] row_s   [3];
    logic        vout_s  [3];

    exp_t exp_q [3][$];
    int   errors = 0;
    int   checks = 0;

    upsampler_h_zero_insert_window #(.IMG_WIDTH(4), .IMG_HEIGHT(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_s[0]), .valid_i(valid_s[0]),
        .ready_o(ready_s[0]), .window_o(win_s[0]), .col_o(col_s[0]),
        .row_o(row_s[0]), .valid_o(vout_s[0])
    );

    upsampler_h_zero_insert_window #(.IMG_WIDTH(2), .IMG_HEIGHT(2)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_s[1]), .valid_i(valid_s[1]),
        .ready_o(ready_s[1]), .window_o(win_s[1]), .col_o(col_s[1]),
        .row_o(row_s[1]), .valid_o(vout_s[1])
    );

    upsampler_h_zero_insert_window #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_c (
        .clk_i(clk), .rst_i(rst_n), .data_i(data_s[2]), .valid_i(valid_s[2]),
        .ready_o(ready_s[2]), .window_o(win_s[2]), .col_o(col_s[2]),
        .row_o(row_s[2]), .valid_o(vout_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check_val(input string name, input logic [63:0] actual,
                                      input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endfunction

    task automatic push_exp(input int idx, input int col, input int row,
                            input logic [15:0] l, input logic [15:0] c, input logic [15:0] r);
        exp_t e;
        e.col = 16'(col);
        e.row = 16'(row);
        e.win = {l, c, r};
        exp_q[idx].push_back(e);
    endtask

    // Zero-stuffed row: even col -> [0,p,0], odd col -> [p(k),0,p(k+1)], last replicates.
    task automatic push_row(input int idx, input int row, input logic [15:0] p [4], input int w);
        for (int k = 0; k < w; k++) begin
            push_exp(idx, 2 * k, row, 16'h0000, p[k], 16'h0000);
            if (k == w - 1) push_exp(idx, 2 * k + 1, row, p[k], 16'h0000, p[k]);
            else            push_exp(idx, 2 * k + 1, row, p[k], 16'h0000, p[k + 1]);
        end
    endtask

    task automatic check_output(input int idx);
        exp_t e;
        checks++;
        if (exp_q[idx].size() == 0) begin
            errors++;
            $display("[TB] FAIL dut%0d unexpected window: got col=%0d row=%0d win=%h expected none",
                     idx, col_s[idx], row_s[idx], win_s[idx]);
        end else begin
            e = exp_q[idx].pop_front();
            if (col_s[idx] !== e.col || row_s[idx] !== e.row || win_s[idx] !== e.win) begin
                errors++;
                $display("[TB] FAIL dut%0d window: got col=%0d row=%0d win=%h expected col=%0d row=%0d win=%h",
                         idx, col_s[idx], row_s[idx], win_s[idx], e.col, e.row, e.win);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vout_s[i] === 1'b1) check_output(i);
        end
    end

    // Offers one pixel and returns #1 after the transfer edge; junk scrambles data_i while stalled.
    task automatic apply_stimulus(input int idx, input logic [15:0] pix, input int gap, input bit junk);
        int n;
        if (gap > 0) begin
            valid_s[idx] = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        data_s[idx]  = pix;
        valid_s[idx] = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (ready_s[idx] === 1'b1) begin
                data_s[idx] = pix;
                @(posedge clk);
                #1;
                valid_s[idx] = 1'b0;
                return;
            end
            if (junk) data_s[idx] = pix ^ 16'h5A5A ^ 16'(n);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut%0d transfer timeout: got ready=0 for 100 cycles expected ready=1", idx);
                valid_s[idx] = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain(input int idx, input string name);
        repeat (8) @(posedge clk);
        #1;
        check_val(name, 64'(exp_q[idx].size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] row_a [4];
        logic [15:0] row_j [4];
        logic [15:0] row_r [4];
        logic [15:0] r0 [4];
        logic [15:0] r1 [4];
        logic [15:0] r2 [4];
        int gaps [4];

        for (int i = 0; i < 3; i++) begin
            data_s[i]  = 16'h0000;
            valid_s[i] = 1'b0;
        end
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset ready dut%0d", i), 64'(ready_s[i]), 64'd0);
            check_val($sformatf("reset valid dut%0d", i), 64'(vout_s[i]), 64'd0);
            check_val($sformatf("reset window dut%0d", i), 64'(win_s[i]), 64'd0);
            check_val($sformatf("reset col dut%0d", i), 64'(col_s[i]), 64'd0);
            check_val($sformatf("reset row dut%0d", i), 64'(row_s[i]), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check_val($sformatf("ready after release dut%0d", i), 64'(ready_s[i]), 64'd1);

        // Continuous offer, W=4: hand-written window list.
        $display("[TB] test 1: continuous row W=4");
        push_exp(0, 0, 0, 16'h0000, 16'h3C00, 16'h0000);
        push_exp(0, 1, 0, 16'h3C00, 16'h0000, 16'h4000);
        push_exp(0, 2, 0, 16'h0000, 16'h4000, 16'h0000);
        push_exp(0, 3, 0, 16'h4000, 16'h0000, 16'h4200);
        push_exp(0, 4, 0, 16'h0000, 16'h4200, 16'h0000);
        push_exp(0, 5, 0, 16'h4200, 16'h0000, 16'h4400);
        push_exp(0, 6, 0, 16'h0000, 16'h4400, 16'h0000);
        push_exp(0, 7, 0, 16'h4400, 16'h0000, 16'h4400);
        row_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(0, row_a[k], 0, 1'b0);
            check_val($sformatf("t1 ready after transfer %0d", k), 64'(ready_s[0]), (k == 0) ? 64'd1 : 64'd0);
        end
        @(posedge clk);
        #1;
        check_val("t1 ready during tail", 64'(ready_s[0]), 64'd0);
        @(posedge clk);
        #1;
        check_val("t1 ready after tail", 64'(ready_s[0]), 64'd1);
        drain(0, "t1 queue empty");

        $display("[TB] test 2: same row with valid gaps");
        push_row(0, 0, row_a, 4);
        gaps = '{3, 1, 4, 2};
        for (int k = 0; k < 4; k++) apply_stimulus(0, row_a[k], gaps[k], 1'b0);
        drain(0, "t2 queue empty");
        check_val("t2 valid idle", 64'(vout_s[0]), 64'd0);

        $display("[TB] test 6: data_i changes while stalled");
        row_j = '{16'h3800, 16'h3A00, 16'hBC00, 16'h0001};
        push_row(0, 0, row_j, 4);
        for (int k = 0; k < 4; k++) apply_stimulus(0, row_j[k], 0, 1'b1);
        drain(0, "t6 queue empty");

        $display("[TB] test 4: async reset mid-row");
        push_exp(0, 0, 0, 16'h0000, 16'h4800, 16'h0000);
        push_exp(0, 1, 0, 16'h4800, 16'h0000, 16'h4A00);
        apply_stimulus(0, 16'h4800, 0, 1'b0);
        apply_stimulus(0, 16'h4A00, 0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t4 valid drops async", 64'(vout_s[0]), 64'd0);
        check_val("t4 ready drops async", 64'(ready_s[0]), 64'd0);
        check_val("t4 partial row seen", 64'(exp_q[0].size()), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        row_r = '{16'h4C00, 16'h0000, 16'h8001, 16'h7BFF};
        push_row(0, 0, row_r, 4);
        for (int k = 0; k < 4; k++) apply_stimulus(0, row_r[k], 0, 1'b0);
        drain(0, "t4 queue empty");

        $display("[TB] test 3: W=2 H=2 row wrap");
        r0 = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000};
        r1 = '{16'h4200, 16'h4400, 16'h0000, 16'h0000};
        r2 = '{16'h4500, 16'h4600, 16'h0000, 16'h0000};
        push_row(1, 0, r0, 2);
        push_row(1, 1, r1, 2);
        push_row(1, 0, r2, 2);
        for (int k = 0; k < 2; k++) apply_stimulus(1, r0[k], 0, 1'b0);
        for (int k = 0; k < 2; k++) apply_stimulus(1, r1[k], 1, 1'b0);
        for (int k = 0; k < 2; k++) apply_stimulus(1, r2[k], 0, 1'b0);
        drain(1, "t3 queue empty");

        $display("[TB] test 5: W=1 single pixel");
        push_exp(2, 0, 0, 16'h0000, 16'h3C00, 16'h0000);
        push_exp(2, 1, 0, 16'h3C00, 16'h0000, 16'h3C00);
        apply_stimulus(2, 16'h3C00, 0, 1'b0);
        check_val("t5 ready during tail", 64'(ready_s[2]), 64'd0);
        @(posedge clk);
        #1;
        check_val("t5 ready after tail", 64'(ready_s[2]), 64'd1);
        drain(2, "t5 queue empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
